// File: rtl/dcache_controller.sv
// Control FSM for the direct-mapped L1 data cache: hit handling, dirty-line writeback,
// line allocation over the L2 word handshake, clflush, and saturating perf counters.
module dcache_controller #(
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_req_valid,
    input  logic [1:0]                pipe_req_type,
    output logic                      pipe_req_fulfilled,
    output logic                      l2_req_valid,
    output logic                      l2_req_store,
    input  logic                      l2_req_fulfilled,
    input  logic                      counter_done,
    input  logic                      valid_block_match,
    input  logic                      valid_dirty_bit,
    output logic                      flush_mode,
    output logic                      load_mode,
    output logic                      clear_selected_dirty_bit,
    output logic                      set_selected_dirty_bit,
    output logic                      perform_write,
    output logic                      clear_selected_valid_bit,
    output logic                      finish_new_line_install,
    output logic                      set_new_l2_block_address,
    output logic                      use_dirty_tag_for_l2_block_address,
    output logic                      reset_counter,
    output logic                      decrement_counter,
    output logic [PERF_CNT_WIDTH-1:0] hit_count,
    output logic [PERF_CNT_WIDTH-1:0] miss_count,
    output logic [PERF_CNT_WIDTH-1:0] writeback_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [1:0] REQ_STORE   = 2'b01;
    localparam logic [1:0] REQ_CLFLUSH = 2'b10;

    state_t state, state_next;
    logic   is_store, is_flush;
    logic   hit_inc, miss_inc, wb_inc;

    assign is_store = (pipe_req_type == REQ_STORE);
    assign is_flush = (pipe_req_type == REQ_CLFLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all datapath strobes; everything is held low while reset is high.
    always_comb begin
        state_next                         = state;
        pipe_req_fulfilled                 = 1'b0;
        l2_req_valid                       = 1'b0;
        l2_req_store                       = 1'b0;
        flush_mode                         = 1'b0;
        load_mode                          = 1'b0;
        clear_selected_dirty_bit           = 1'b0;
        set_selected_dirty_bit             = 1'b0;
        perform_write                      = 1'b0;
        clear_selected_valid_bit           = 1'b0;
        finish_new_line_install            = 1'b0;
        set_new_l2_block_address           = 1'b0;
        use_dirty_tag_for_l2_block_address = 1'b0;
        reset_counter                      = 1'b0;
        decrement_counter                  = 1'b0;
        hit_inc                            = 1'b0;
        miss_inc                           = 1'b0;
        wb_inc                             = 1'b0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (pipe_req_valid) begin
                        if (is_flush) begin
                            if (valid_block_match && valid_dirty_bit) begin
                                set_new_l2_block_address           = 1'b1;
                                use_dirty_tag_for_l2_block_address = 1'b1;
                                reset_counter                      = 1'b1;
                                state_next                         = WRITEBACK;
                            end else if (valid_block_match) begin
                                clear_selected_valid_bit = 1'b1;
                                pipe_req_fulfilled       = 1'b1;
                            end else begin
                                pipe_req_fulfilled = 1'b1;
                            end
                        end else if (valid_block_match) begin
                            pipe_req_fulfilled = 1'b1;
                            hit_inc            = 1'b1;
                            if (is_store) begin
                                perform_write          = 1'b1;
                                set_selected_dirty_bit = 1'b1;
                            end
                        end else if (valid_dirty_bit) begin
                            set_new_l2_block_address           = 1'b1;
                            use_dirty_tag_for_l2_block_address = 1'b1;
                            reset_counter                      = 1'b1;
                            state_next                         = WRITEBACK;
                        end else begin
                            set_new_l2_block_address = 1'b1;
                            reset_counter            = 1'b1;
                            miss_inc                 = 1'b1;
                            state_next               = ALLOCATE;
                        end
                    end
                end

                WRITEBACK: begin
                    flush_mode   = 1'b1;
                    l2_req_valid = 1'b1;
                    l2_req_store = 1'b1;
                    if (l2_req_fulfilled) begin
                        if (!counter_done) begin
                            decrement_counter = 1'b1;
                        end else begin
                            clear_selected_dirty_bit = 1'b1;
                            wb_inc                   = 1'b1;
                            if (is_flush) begin
                                clear_selected_valid_bit = 1'b1;
                                pipe_req_fulfilled       = 1'b1;
                                state_next               = IDLE;
                            end else begin
                                set_new_l2_block_address = 1'b1;
                                reset_counter            = 1'b1;
                                miss_inc                 = 1'b1;
                                state_next               = ALLOCATE;
                            end
                        end
                    end
                end

                ALLOCATE: begin
                    load_mode    = 1'b1;
                    l2_req_valid = 1'b1;
                    if (l2_req_fulfilled) begin
                        perform_write = 1'b1;
                        if (!counter_done) begin
                            decrement_counter = 1'b1;
                        end else begin
                            // Request is re-evaluated as a hit on the following IDLE cycle.
                            finish_new_line_install  = 1'b1;
                            clear_selected_dirty_bit = 1'b1;
                            state_next               = IDLE;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + PERF_CNT_WIDTH'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + PERF_CNT_WIDTH'(1);
            end
            if (wb_inc && (writeback_count != '1)) begin
                writeback_count <= writeback_count + PERF_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: IDLE decode table, directed multi-cycle sequences and random
// traffic against an architectural memory / cache-state model, with a simple datapath stand-in.
module tb_dcache_controller;

    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_req_valid;
    logic [1:0]    pipe_req_type;
    logic          pipe_req_fulfilled;
    logic          l2_req_valid, l2_req_store, l2_req_fulfilled;
    logic          counter_done, valid_block_match, valid_dirty_bit;
    logic          flush_mode, load_mode, clear_selected_dirty_bit, set_selected_dirty_bit;
    logic          perform_write, clear_selected_valid_bit, finish_new_line_install;
    logic          set_new_l2_block_address, use_dirty_tag_for_l2_block_address;
    logic          reset_counter, decrement_counter;
    logic [CW-1:0] hit_count, miss_count, writeback_count;

    always #5 clk = ~clk;

    dcache_controller #(.PERF_CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
        .pipe_req_fulfilled(pipe_req_fulfilled),
        .l2_req_valid(l2_req_valid), .l2_req_store(l2_req_store),
        .l2_req_fulfilled(l2_req_fulfilled), .counter_done(counter_done),
        .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit),
        .flush_mode(flush_mode), .load_mode(load_mode),
        .clear_selected_dirty_bit(clear_selected_dirty_bit),
        .set_selected_dirty_bit(set_selected_dirty_bit),
        .perform_write(perform_write),
        .clear_selected_valid_bit(clear_selected_valid_bit),
        .finish_new_line_install(finish_new_line_install),
        .set_new_l2_block_address(set_new_l2_block_address),
        .use_dirty_tag_for_l2_block_address(use_dirty_tag_for_l2_block_address),
        .reset_counter(reset_counter), .decrement_counter(decrement_counter),
        .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
    );

    // Request: addr = {tag[1:0], set[1:0], word[2:0]}
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  rset, rtag;
    logic [2:0]  rword;
    assign rset  = req_addr[4:3];
    assign rtag  = req_addr[6:5];
    assign rword = req_addr[2:0];

    // Datapath and L2 stand-in
    logic        env_init;
    logic [31:0] cdata [0:3][0:7];
    logic [31:0] mem   [0:127];
    logic        cvalid [0:3];
    logic        cdirty [0:3];
    logic [1:0]  ctag   [0:3];
    logic [1:0]  l2_tag;
    logic [2:0]  cnt;
    logic [31:0] l2_fetched_word, load_data;
    int          n_st, n_ld, n_pw, n_fin, n_conflict;

    logic ovr, t_match, t_dirty;
    logic env_match, env_dirty;
    assign env_match         = cvalid[rset] && (ctag[rset] == rtag);
    assign env_dirty         = cvalid[rset] && cdirty[rset];
    assign valid_block_match = ovr ? t_match : env_match;
    assign valid_dirty_bit   = ovr ? t_dirty : env_dirty;
    assign counter_done      = (cnt == 3'd0);
    assign l2_fetched_word   = mem[{l2_tag, rset, cnt}];
    assign load_data         = cdata[rset][rword];

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5000000 + 32'(i) * 32'h00010203;
    endfunction

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            for (int i = 0; i < 4; i++) begin
                cvalid[i] <= 1'b0;
                cdirty[i] <= 1'b0;
                ctag[i]   <= 2'd0;
            end
            cnt        <= 3'd0;
            l2_tag     <= 2'd0;
            n_st       <= 0;
            n_ld       <= 0;
            n_pw       <= 0;
            n_fin      <= 0;
            n_conflict <= 0;
        end else begin
            if (set_new_l2_block_address)
                l2_tag <= use_dirty_tag_for_l2_block_address ? ctag[rset] : rtag;
            if (reset_counter) cnt <= 3'b111;
            else if (decrement_counter) cnt <= cnt - 3'd1;
            if (perform_write) begin
                if (load_mode) cdata[rset][cnt] <= l2_fetched_word;
                else cdata[rset][rword] <= req_data;
            end
            if (flush_mode && l2_req_valid && l2_req_fulfilled)
                mem[{l2_tag, rset, cnt}] <= cdata[rset][cnt];
            if (set_selected_dirty_bit) cdirty[rset] <= 1'b1;
            if (clear_selected_dirty_bit) cdirty[rset] <= 1'b0;
            if (clear_selected_valid_bit) cvalid[rset] <= 1'b0;
            if (finish_new_line_install) begin
                cvalid[rset] <= 1'b1;
                ctag[rset]   <= l2_tag;
            end
            if (l2_req_valid && l2_req_fulfilled) begin
                if (l2_req_store) n_st <= n_st + 1;
                else n_ld <= n_ld + 1;
            end
            if (perform_write) n_pw <= n_pw + 1;
            if (finish_new_line_install) n_fin <= n_fin + 1;
            if ((set_selected_dirty_bit && clear_selected_dirty_bit) ||
                (clear_selected_valid_bit && finish_new_line_install))
                n_conflict <= n_conflict + 1;
        end
    end

    // Architectural reference: memory contents and request-level cache state
    logic [31:0]   gmem [0:127];
    logic          gv [0:3];
    logic          gd [0:3];
    logic [1:0]    gt [0:3];
    logic [CW-1:0] ghit, gmiss, gwb;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    function automatic logic [13:0] outs();
        return {pipe_req_fulfilled, l2_req_valid, l2_req_store, flush_mode, load_mode,
                clear_selected_dirty_bit, set_selected_dirty_bit, perform_write,
                clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address,
                use_dirty_tag_for_l2_block_address, reset_counter, decrement_counter};
    endfunction

    // One pipeline request from issue to fulfilment; exp_k < 0 skips the latency check.
    task automatic do_req(input logic [1:0] ty, input logic [6:0] addr, input logic [31:0] data,
                          input bit alt, input int exp_k);
        int st0, ld0, pw0, fin0, k, exp_st, exp_ld;
        bit done, tog, hit;
        logic [1:0] s, t;
        logic [31:0] exp_data;
        s = addr[4:3];
        t = addr[6:5];
        hit = gv[s] && (gt[s] == t);
        exp_st = 0;
        exp_ld = 0;
        exp_data = gmem[addr];
        if (ty == 2'b10) begin
            if (hit) begin
                if (gd[s]) begin
                    exp_st = 8;
                    gwb = sat(gwb);
                end
                gv[s] = 1'b0;
                gd[s] = 1'b0;
            end
        end else begin
            if (!hit) begin
                if (gv[s] && gd[s]) begin
                    exp_st = 8;
                    gwb = sat(gwb);
                end
                exp_ld = 8;
                gmiss = sat(gmiss);
                gv[s] = 1'b1;
                gt[s] = t;
                gd[s] = 1'b0;
            end
            ghit = sat(ghit);
            if (ty == 2'b01) begin
                gd[s] = 1'b1;
                gmem[addr] = data;
            end
        end

        st0 = n_st; ld0 = n_ld; pw0 = n_pw; fin0 = n_fin;
        @(negedge clk);
        req_addr = addr;
        req_data = data;
        pipe_req_type = ty;
        pipe_req_valid = 1'b1;
        done = 1'b0;
        tog = 1'b0;
        k = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (alt) begin
                l2_req_fulfilled = l2_req_valid && tog;
                if (l2_req_valid) tog = !tog;
            end else begin
                l2_req_fulfilled = l2_req_valid && ($urandom_range(0, 2) != 0);
            end
            #1;
            if (pipe_req_fulfilled) begin
                done = 1'b1;
                k = i;
                if (ty != 2'b01 && ty != 2'b10) chk("load_data", load_data, exp_data);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no fulfil expected fulfil (addr %0h)", addr);
        end
        @(posedge clk);
        #1;
        pipe_req_valid = 1'b0;
        l2_req_fulfilled = 1'b0;
        chk("l2_store_words", 32'(n_st - st0), 32'(exp_st));
        chk("l2_load_words", 32'(n_ld - ld0), 32'(exp_ld));
        chk("perform_writes", 32'(n_pw - pw0), 32'(exp_ld + ((ty == 2'b01) ? 1 : 0)));
        chk("line_installs", 32'(n_fin - fin0), 32'((exp_ld != 0) ? 1 : 0));
        chk("hit_count", 32'(hit_count), 32'(ghit));
        chk("miss_count", 32'(miss_count), 32'(gmiss));
        chk("writeback_count", 32'(writeback_count), 32'(gwb));
        if (exp_k >= 0) chk("latency", 32'(k), 32'(exp_k));
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  ty;
        logic        m;
        logic        d;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int words;
        tbl[0]  = '{1'b0, 2'b00, 1'b1, 1'b1, 14'h0000};
        tbl[1]  = '{1'b1, 2'b00, 1'b1, 1'b0, 14'h2000};
        tbl[2]  = '{1'b1, 2'b01, 1'b1, 1'b1, 14'h20C0};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 1'b1, 14'h000E};
        tbl[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 14'h000A};
        tbl[5]  = '{1'b1, 2'b01, 1'b0, 1'b1, 14'h000E};
        tbl[6]  = '{1'b1, 2'b01, 1'b0, 1'b0, 14'h000A};
        tbl[7]  = '{1'b1, 2'b10, 1'b1, 1'b1, 14'h000E};
        tbl[8]  = '{1'b1, 2'b10, 1'b1, 1'b0, 14'h2020};
        tbl[9]  = '{1'b1, 2'b10, 1'b0, 1'b1, 14'h2000};
        tbl[10] = '{1'b1, 2'b11, 1'b1, 1'b0, 14'h2000};
        tbl[11] = '{1'b1, 2'b11, 1'b0, 1'b0, 14'h000A};
        tbl[12] = '{1'b0, 2'b01, 1'b0, 1'b1, 14'h0000};

        for (int i = 0; i < 128; i++) gmem[i] = init_word(i);
        for (int i = 0; i < 4; i++) begin
            gv[i] = 1'b0;
            gd[i] = 1'b0;
            gt[i] = 2'd0;
        end
        ghit = '0; gmiss = '0; gwb = '0;

        reset = 1'b1;
        env_init = 1'b1;
        pipe_req_valid = 1'b0;
        pipe_req_type = 2'b00;
        l2_req_fulfilled = 1'b0;
        req_addr = '0;
        req_data = '0;
        ovr = 1'b0;
        t_match = 1'b0;
        t_dirty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        env_init = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_hit_count", 32'(hit_count), 0);
        chk("rst_miss_count", 32'(miss_count), 0);
        chk("rst_wb_count", 32'(writeback_count), 0);
        chk("rst_outputs", 32'(outs()), 0);

        // IDLE decode, applied mid-cycle and withdrawn before the next edge
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ovr = 1'b1;
            pipe_req_valid = tbl[i].v;
            pipe_req_type = tbl[i].ty;
            t_match = tbl[i].m;
            t_dirty = tbl[i].d;
            #1;
            chk($sformatf("idle_vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            pipe_req_valid = 1'b0;
            ovr = 1'b0;
        end

        // Directed: cold fill, store hit, dirty conflict, clflush dirty/absent
        do_req(2'b00, 7'b00_11_101, 32'h0, 1'b1, 17);
        do_req(2'b01, 7'b00_11_010, 32'hDEADBEEF, 1'b1, 0);
        do_req(2'b00, 7'b01_11_010, 32'h0, 1'b1, 33);
        do_req(2'b01, 7'b01_11_100, 32'h12345678, 1'b1, 0);
        do_req(2'b10, 7'b01_11_000, 32'h0, 1'b1, 16);
        do_req(2'b00, 7'b01_11_100, 32'h0, 1'b1, 17);
        do_req(2'b10, 7'b10_00_000, 32'h0, 1'b1, 0);
        do_req(2'b00, 7'b00_11_010, 32'h0, 1'b1, 17);

        // Reset after the third allocate word of a cold miss
        @(negedge clk);
        req_addr = 7'b00_01_011;
        pipe_req_type = 2'b00;
        pipe_req_valid = 1'b1;
        words = 0;
        for (int i = 0; i < 50 && words < 3; i++) begin
            if (i > 0) @(negedge clk);
            l2_req_fulfilled = l2_req_valid && load_mode;
            if (l2_req_fulfilled) words++;
        end
        chk("rst_test_words", 32'(words), 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        l2_req_fulfilled = 1'b0;
        #1;
        chk("reset_forces_outputs", 32'(outs()), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pipe_req_valid = 1'b0;
        #1;
        chk("post_reset_l2_valid", 32'(l2_req_valid), 0);
        chk("post_reset_hits", 32'(hit_count), 0);
        chk("post_reset_misses", 32'(miss_count), 0);
        chk("post_reset_wbs", 32'(writeback_count), 0);
        ghit = '0; gmiss = '0; gwb = '0;
        do_req(2'b00, 7'b00_01_011, 32'h0, 1'b1, 17);

        // Random traffic; the narrow counters also exercise saturation
        for (int i = 0; i < 200; i++) begin
            do_req(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), $urandom, 1'b0, -1);
        end
        chk("strobe_conflicts", 32'(n_conflict), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
